// File: rtl/rrf_flag_retsel.sv
// rrf_flag_retsel
//   Retire-side front end of the architectural flag register. Picks the
//   youngest committing flag writer out of a retire bundle and delivers it
//   two cycles later on a single registered write port. A per-thread shadow
//   of committed flags, plus bypass from the two in-flight stages, gives
//   readers the newest value at all times.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ret_en            retire bundle valid this cycle
//   ret_thread        thread of the bundle
//   ret_slot_valid    per-slot retiring instruction (slot 0 oldest)
//   ret_slot_fwen     per-slot flag write enable
//   ret_slot_excpt    per-slot exception
//   ret_slot_flags    packed per-slot flags, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   flush             cancels the incoming bundle and stage S1
//   write0_data       flag write data (holds when write0_wen=0)
//   write0_wen        flag write enable, one cycle per captured bundle
//   write_thread      thread of the write (holds when write0_wen=0)
//   fwd_thread        thread whose flags are forwarded
//   fwd_flags         newest in-flight or committed flags of fwd_thread
//   pend              a write is in flight in S1 or S2
//   wr_count          saturating flag-write count of fwd_thread
module rrf_flag_retsel #(
  parameter int NSLOT      = 9,
  parameter int DATA_WIDTH = 6,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ret_en,
  input  logic                        ret_thread,
  input  logic [NSLOT-1:0]            ret_slot_valid,
  input  logic [NSLOT-1:0]            ret_slot_fwen,
  input  logic [NSLOT-1:0]            ret_slot_excpt,
  input  logic [NSLOT*DATA_WIDTH-1:0] ret_slot_flags,
  input  logic                        flush,
  output logic [DATA_WIDTH-1:0]       write0_data,
  output logic                        write0_wen,
  output logic                        write_thread,
  input  logic                        fwd_thread,
  output logic [DATA_WIDTH-1:0]       fwd_flags,
  output logic                        pend,
  output logic [CNT_W-1:0]            wr_count
);

  logic                  sel_hit;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  chain_ok;
  logic                  capture;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_thread;

  logic [DATA_WIDTH-1:0] shadow [2];
  logic [CNT_W-1:0]      cnt    [2];

  // Walk oldest to youngest: an exception stops the commit chain at and
  // beyond its own slot; invalid slots simply do not commit. The last
  // committing writer seen is the youngest one.
  always_comb begin
    sel_hit  = 1'b0;
    sel_data = '0;
    chain_ok = 1'b1;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (ret_slot_excpt[i])
        chain_ok = 1'b0;
      if (chain_ok && ret_slot_valid[i] && ret_slot_fwen[i]) begin
        sel_hit  = 1'b1;
        sel_data = ret_slot_flags[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign capture = ret_en & ~flush & sel_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_data      <= '0;
      s1_thread    <= 1'b0;
      write0_wen   <= 1'b0;
      write0_data  <= '0;
      write_thread <= 1'b0;
      for (int unsigned t = 0; t < 2; t++) begin
        shadow[t] <= '0;
        cnt[t]    <= '0;
      end
    end else begin
      s1_valid <= capture;
      if (capture) begin
        s1_data   <= sel_data;
        s1_thread <= ret_thread;
      end

      // Flush cancels S1 but not a write already sitting in S2.
      write0_wen <= s1_valid & ~flush;
      if (s1_valid && !flush) begin
        write0_data  <= s1_data;
        write_thread <= s1_thread;
      end

      if (write0_wen) begin
        shadow[write_thread] <= write0_data;
        if (cnt[write_thread] != '1)
          cnt[write_thread] <= cnt[write_thread] + 1'b1;
      end
    end
  end

  always_comb begin
    fwd_flags = shadow[fwd_thread];
    if (s1_valid && (s1_thread == fwd_thread))
      fwd_flags = s1_data;
    else if (write0_wen && (write_thread == fwd_thread))
      fwd_flags = write0_data;
  end

  assign pend     = s1_valid | write0_wen;
  assign wr_count = cnt[fwd_thread];

endmodule

// File: tb/tb_rrf_flag_retsel.sv
module tb_rrf_flag_retsel;

  localparam int NSLOT = 9;
  localparam int DW    = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             ret_en;
  logic             ret_thread;
  logic [NSLOT-1:0] ret_slot_valid;
  logic [NSLOT-1:0] ret_slot_fwen;
  logic [NSLOT-1:0] ret_slot_excpt;
  logic [NSLOT*DW-1:0] ret_slot_flags;
  logic             flush;
  logic             fwd_thread;

  logic [DW-1:0]    write0_data;
  logic             write0_wen;
  logic             write_thread;
  logic [DW-1:0]    fwd_flags;
  logic             pend;
  logic [15:0]      wr_count;

  logic [DW-1:0]    s_write0_data;
  logic             s_write0_wen;
  logic             s_write_thread;
  logic [DW-1:0]    s_fwd_flags;
  logic             s_pend;
  logic [1:0]       s_wr_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rrf_flag_retsel u_dut (
    .clk(clk), .rst(rst), .ret_en(ret_en), .ret_thread(ret_thread),
    .ret_slot_valid(ret_slot_valid), .ret_slot_fwen(ret_slot_fwen),
    .ret_slot_excpt(ret_slot_excpt), .ret_slot_flags(ret_slot_flags),
    .flush(flush), .write0_data(write0_data), .write0_wen(write0_wen),
    .write_thread(write_thread), .fwd_thread(fwd_thread),
    .fwd_flags(fwd_flags), .pend(pend), .wr_count(wr_count)
  );

  // Narrow-counter instance for the saturation check; shares all stimulus.
  rrf_flag_retsel #(.NSLOT(9), .DATA_WIDTH(6), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .ret_en(ret_en), .ret_thread(ret_thread),
    .ret_slot_valid(ret_slot_valid), .ret_slot_fwen(ret_slot_fwen),
    .ret_slot_excpt(ret_slot_excpt), .ret_slot_flags(ret_slot_flags),
    .flush(flush), .write0_data(s_write0_data), .write0_wen(s_write0_wen),
    .write_thread(s_write_thread), .fwd_thread(fwd_thread),
    .fwd_flags(s_fwd_flags), .pend(s_pend), .wr_count(s_wr_count)
  );

  typedef struct {
    string            name;
    logic             thread;
    logic [NSLOT-1:0] valid;
    logic [NSLOT-1:0] fwen;
    logic [NSLOT-1:0] excpt;
    logic [NSLOT*DW-1:0] flags;
    logic             exp_wen;
    logic [DW-1:0]    exp_data;
  } vec_t;

  vec_t vecs [7];

  // Expected state of the write port, shadows and counters.
  logic [DW-1:0] m_data;
  logic          m_thread;
  logic [DW-1:0] m_shadow [2];
  int            m_cnt    [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NSLOT*DW-1:0] base_flags();
    logic [NSLOT*DW-1:0] f;
    for (int i = 0; i < NSLOT; i++) f[i*DW +: DW] = 6'(6'h30 + i);
    return f;
  endfunction

  function automatic logic [NSLOT*DW-1:0] setf(input logic [NSLOT*DW-1:0] f,
                                               input int s, input logic [DW-1:0] v);
    logic [NSLOT*DW-1:0] r;
    r = f;
    r[s*DW +: DW] = v;
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ret_en = 1'b0; flush = 1'b0;
    ret_slot_valid = '0; ret_slot_fwen = '0; ret_slot_excpt = '0;
  endtask

  task automatic bundle(input logic thr, input logic [DW-1:0] val);
    ret_en = 1'b1; ret_thread = thr;
    ret_slot_valid = '1; ret_slot_fwen = 9'h001; ret_slot_excpt = '0;
    ret_slot_flags = setf(base_flags(), 0, val);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NSLOT*DW-1:0] f;

    // Directed single-bundle vectors.
    f = setf(base_flags(), 3, 6'h15);
    vecs[0] = '{"single", 1'b0, 9'h1FF, 9'h008, 9'h000, f, 1'b1, 6'h15};
    f = setf(setf(setf(base_flags(), 1, 6'h01), 4, 6'h04), 8, 6'h08);
    vecs[1] = '{"youngest", 1'b0, 9'h1FF, 9'h112, 9'h000, f, 1'b1, 6'h08};
    f = setf(setf(base_flags(), 2, 6'h22), 6, 6'h26);
    vecs[2] = '{"excpt5", 1'b0, 9'h1FF, 9'h044, 9'h020, f, 1'b1, 6'h22};
    vecs[3] = '{"excpt0", 1'b0, 9'h1FF, 9'h044, 9'h001, f, 1'b0, 6'h00};
    f = setf(base_flags(), 7, 6'h3F);
    vecs[4] = '{"invalid_gap", 1'b1, 9'h1FB, 9'h080, 9'h000, f, 1'b1, 6'h3F};
    f = setf(base_flags(), 8, 6'h3E);
    vecs[5] = '{"fwen_invalid", 1'b1, 9'h0FF, 9'h100, 9'h000, f, 1'b0, 6'h00};
    f = setf(setf(base_flags(), 1, 6'h11), 4, 6'h14);
    vecs[6] = '{"excpt_on_writer", 1'b0, 9'h1FF, 9'h012, 9'h010, f, 1'b1, 6'h11};

    m_data = '0; m_thread = 1'b0;
    m_shadow[0] = '0; m_shadow[1] = '0;
    m_cnt[0] = 0; m_cnt[1] = 0;

    rst = 1'b1; fwd_thread = 1'b0; ret_thread = 1'b0; ret_slot_flags = '0;
    idle();
    next_cycle(); next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wen",   write0_wen,   0);
    chk("rst_data",  write0_data,  0);
    chk("rst_thr",   write_thread, 0);
    chk("rst_pend",  pend,         0);
    chk("rst_cnt",   wr_count,     0);
    chk("rst_fwd",   fwd_flags,    0);
    next_cycle();

    foreach (vecs[v]) begin
      ret_en = 1'b1; flush = 1'b0;
      ret_thread = vecs[v].thread; fwd_thread = vecs[v].thread;
      ret_slot_valid = vecs[v].valid; ret_slot_fwen = vecs[v].fwen;
      ret_slot_excpt = vecs[v].excpt; ret_slot_flags = vecs[v].flags;
      @(negedge clk);
      chk({vecs[v].name, "_pendT"}, pend, 0);
      next_cycle(); idle();
      @(negedge clk);
      chk({vecs[v].name, "_pendT1"}, pend, 32'(vecs[v].exp_wen));
      if (vecs[v].exp_wen) chk({vecs[v].name, "_fwdT1"}, fwd_flags, 32'(vecs[v].exp_data));
      next_cycle();
      @(negedge clk);
      if (vecs[v].exp_wen) begin
        m_data = vecs[v].exp_data; m_thread = vecs[v].thread;
        m_shadow[vecs[v].thread] = vecs[v].exp_data;
        m_cnt[vecs[v].thread]++;
      end
      chk({vecs[v].name, "_wen"},  write0_wen,   32'(vecs[v].exp_wen));
      chk({vecs[v].name, "_data"}, write0_data,  32'(m_data));
      chk({vecs[v].name, "_thr"},  write_thread, 32'(m_thread));
      next_cycle();
      @(negedge clk);
      chk({vecs[v].name, "_wenT3"}, write0_wen, 0);
      chk({vecs[v].name, "_cnt"},   wr_count,   32'(m_cnt[vecs[v].thread]));
      chk({vecs[v].name, "_shadow"}, fwd_flags, 32'(m_shadow[vecs[v].thread]));
      next_cycle();
    end

    // Flush in T+1 kills the S1 entry.
    fwd_thread = 1'b0;
    bundle(1'b0, 6'h2A);
    next_cycle(); idle(); flush = 1'b1;
    next_cycle(); idle();
    @(negedge clk);
    chk("flushT1_wen",  write0_wen, 0);
    chk("flushT1_pend", pend,       0);
    chk("flushT1_fwd",  fwd_flags,  32'(6'h11));
    next_cycle();

    // Flush in T+2 leaves the write at the outputs intact.
    bundle(1'b0, 6'h2B);
    next_cycle(); idle();
    next_cycle(); flush = 1'b1;
    @(negedge clk);
    chk("flushT2_wen",  write0_wen,  1);
    chk("flushT2_data", write0_data, 32'(6'h2B));
    next_cycle(); idle();
    @(negedge clk);
    chk("flushT2_shadow", fwd_flags, 32'(6'h2B));
    chk("flushT2_cnt",    wr_count,  5);
    next_cycle();

    // Flush alongside the bundle drops it.
    bundle(1'b0, 6'h2C); flush = 1'b1;
    next_cycle(); idle();
    @(negedge clk);
    chk("flushT0_pend", pend, 0);
    next_cycle();
    @(negedge clk);
    chk("flushT0_wen", write0_wen, 0);
    next_cycle();

    // Back-to-back bundles on thread 1 with forwarding.
    fwd_thread = 1'b1;
    bundle(1'b1, 6'h0A);
    next_cycle(); bundle(1'b1, 6'h0B);
    @(negedge clk);
    chk("b2b_fwdT1",  fwd_flags, 32'(6'h0A));
    chk("b2b_pendT1", pend, 1);
    next_cycle(); idle();
    @(negedge clk);
    chk("b2b_fwdT2",  fwd_flags,   32'(6'h0B));
    chk("b2b_pendT2", pend,        1);
    chk("b2b_wenT2",  write0_wen,  1);
    chk("b2b_dataT2", write0_data, 32'(6'h0A));
    next_cycle();
    @(negedge clk);
    chk("b2b_pendT3", pend,        1);
    chk("b2b_wenT3",  write0_wen,  1);
    chk("b2b_dataT3", write0_data, 32'(6'h0B));
    chk("b2b_thrT3",  write_thread, 1);
    next_cycle();
    @(negedge clk);
    chk("b2b_fwdT4",  fwd_flags, 32'(6'h0B));
    chk("b2b_pendT4", pend,      0);
    chk("b2b_cnt1",   wr_count,  3);
    #1 fwd_thread = 1'b0;
    #1;
    chk("b2b_fwd_thr0", fwd_flags, 32'(6'h2B));
    chk("b2b_cnt0",     wr_count,  5);
    next_cycle();

    // Saturation: four writes to thread 0 after a reset.
    rst = 1'b1;
    next_cycle(); rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      bundle(1'b0, 6'(k));
      next_cycle();
    end
    idle();
    next_cycle(); next_cycle(); next_cycle();
    @(negedge clk);
    chk("sat_cnt_wide",   wr_count,      4);
    chk("sat_cnt_narrow", s_wr_count,    3);
    chk("sat_data",       write0_data,   32'(6'h04));
    chk("sat_narrow_fwd", s_fwd_flags,   32'(6'h04));
    next_cycle();

    // Reset while S1 holds a write.
    fwd_thread = 1'b1;
    bundle(1'b1, 6'h1D);
    next_cycle(); idle(); rst = 1'b1;
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    chk("rstmid_wen",  write0_wen,   0);
    chk("rstmid_data", write0_data,  0);
    chk("rstmid_thr",  write_thread, 0);
    chk("rstmid_pend", pend,         0);
    chk("rstmid_fwd",  fwd_flags,    0);
    chk("rstmid_cnt",  wr_count,     0);
    next_cycle();
    @(negedge clk);
    chk("rstmid_wenT3", write0_wen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rrf_flag_retsel.md
Name: rrf_flag_retsel

Overview:
- Retire-side front end of the architectural flag register: accepts a retire bundle of up to NSLOT instructions.
- Finds the youngest committing flag-writer and produces the single registered write port (write0_data/write0_wen/write_thread) consumed by the flag retirement register.
- Keeps a per-thread shadow of committed flags and forwards the newest in-flight value, so readers never see a stale value during the two-cycle write latency.

Parameters:
- NSLOT, 9, retire slots per bundle; slot 0 oldest.
- DATA_WIDTH, 6, flag word width.
- CNT_W, 16, width of the per-thread flag-write statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ret_en  in  1  retire bundle valid this cycle
- ret_thread  in  1  thread of the bundle
- ret_slot_valid  in  NSLOT  slot holds a retiring instruction
- ret_slot_fwen  in  NSLOT  slot writes flags
- ret_slot_excpt  in  NSLOT  slot raised an exception
- ret_slot_flags  in  NSLOT*DATA_WIDTH  flags of slot i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- flush  in  1  pipeline flush; cancels uncommitted work
- write0_data  out  DATA_WIDTH  flag write data to the retirement register
- write0_wen  out  1  flag write enable
- write_thread  out  1  thread of the write
- fwd_thread  in  1  thread selected for forwarding
- fwd_flags  out  DATA_WIDTH  newest committed-or-in-flight flags of fwd_thread
- pend  out  1  an in-flight write exists for any thread (stage S1 or S2 valid)
- wr_count  out  CNT_W  flag writes for thread 0 while fwd_thread=0, else for thread 1

Behaviour:
- Reset: all registers cleared. write0_wen=0, write0_data=0, write_thread=0, pend=0, wr_count=0, both shadows 0, fwd_flags=0.
- Commit mask, combinational in cycle T with ret_en=1:
  - Slot i commits iff ret_slot_valid[i] and no ret_slot_excpt[j] for j<=i.
  - An excepting slot and all younger slots do not commit.
  - Invalid slots do not break the chain.
- Selection: youngest (highest index) committing slot with fwen=1.
  - If none exists, nothing is captured; S1 valid=0.
- Stage S1, captured at end of T: s1_valid, s1_data, s1_thread.
  - Captured only when ret_en=1 and flush=0; otherwise s1_valid<=0.
- Stage S2 = output registers, loaded at end of T+1:
  - write0_wen<=s1_valid & ~flush.
  - write0_data<=s1_data; write_thread<=s1_thread.
  - write0_wen is high exactly in cycle T+2 for one cycle.
  - Data and thread hold their value when wen=0.
- Flush:
  - Kills a bundle arriving the same cycle and the S1 contents.
  - Does not kill S2: a write already at the outputs completes.
- Back-to-back bundles every cycle are sustained with no stall; each produces its own write.
- Shadow: when write0_wen=1, shadow[write_thread]<=write0_data at end of that cycle.
- Counter: when write0_wen=1, cnt[write_thread] increments, saturating at 2^CNT_W-1.
- fwd_flags, combinational, priority newest first:
  1. S1 if s1_valid and s1_thread==fwd_thread;
  2. else S2 if write0_wen and write_thread==fwd_thread;
  3. else shadow[fwd_thread].
- pend = s1_valid | write0_wen.
- Reset mid-operation: S1, S2, shadows and counters clear on the next edge; no write is issued after reset.

Test Plan:
- Single writer: ret_en, thread 0, slot 3 fwen, flags 6'h15, all slots valid → write0_wen=1 at T+2, write0_data=6'h15, write_thread=0; shadow0=6'h15; wr_count=1.
- Youngest wins: slots 1, 4, 8 fwen with flags 6'h01, 6'h04, 6'h08 → one write of 6'h08 at T+2.
- Exception cut: slots 2, 6 fwen (6'h22, 6'h26), excpt on slot 5 → writes 6'h22. Same stimulus with excpt on slot 0 → no write, pend stays 0.
- Flush:
  - flush in T+1 → write0_wen stays 0 at T+2.
  - flush in T+2 → write at T+2 still occurs.
  - flush with ret_en in T → bundle dropped.
- Back-to-back and forwarding:
  - Bundles at T (thread 1, 6'h0A) and T+1 (thread 1, 6'h0B) → writes at T+2 and T+3.
  - With fwd_thread=1, fwd_flags shows 6'h0A at T+1, 6'h0B at T+2, 6'h0B at T+4; pend is 1 over T+1..T+3.
  - Thread-0 forwarding is unaffected.
- Saturation and reset: preload counter at 16'hFFFF via repeated writes (or with CNT_W=2, three writes) → count holds at max. rst with S1 valid → no write0_wen afterwards; all outputs 0.
